// File: rtl/instr_mem_fetch.sv
// Synchronous-read instruction memory for the MIPS IF stage.
// It clears itself to NOP after reset, supports a runtime program-load port, and has a fetch/stall/flush handshake.
module instr_mem_fetch #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h2400_0241
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready,
  output logic [DATA_W-1:0] ins_out,
  output logic              ins_valid,
  output logic              addr_err
);

  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   init_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                pc_ok_c;
  logic                wr_ok_c;
  logic                mem_we_c;
  logic [IDX_W-1:0]    mem_waddr_c;
  logic [DATA_W-1:0]   mem_wdata_c;

  // Full-width range checks: upper address bits are never silently dropped.
  assign pc_ok_c = {1'b0, pc} < DEPTH_X;
  assign wr_ok_c = {1'b0, wr_addr} < DEPTH_X;

  // The single write port is shared by the clear sequencer and the program loader.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = init_cnt[IDX_W-1:0];
    mem_wdata_c = NOP_WORD;
    if (state == S_INIT) begin
      mem_we_c = 1'b1;
    end else if (wr_en && wr_ok_c) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = wr_addr[IDX_W-1:0];
      mem_wdata_c = wr_data;
    end
  end

  // The memory array is not reset; non-blocking writes give read-first collisions.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      ready     <= 1'b0;
      ins_out   <= NOP_WORD;
      ins_valid <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + ADDR_W'(1);
          if (init_cnt == LAST) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (flush) begin
            ins_out   <= NOP_WORD;
            ins_valid <= 1'b1;
            addr_err  <= 1'b0;
          end else if (stall) begin
            ins_out   <= ins_out;
          end else if (fetch_en) begin
            ins_valid <= 1'b1;
            if (pc_ok_c) begin
              ins_out  <= mem[pc[IDX_W-1:0]];
              addr_err <= 1'b0;
            end else begin
              ins_out  <= NOP_WORD;
              addr_err <= 1'b1;
            end
          end else begin
            ins_valid <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: a DEPTH=16 instance (a) and a DEPTH=1000 instance (b).
// Both instances share their stimulus.
module tb_instr_mem_fetch;

  localparam logic [31:0] NOP = 32'h2400_0241;
  localparam logic [31:0] W0  = 32'h2801_1DD0;
  localparam logic [31:0] W7  = 32'h2CE7_21CF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pc;
  logic        fetch_en, stall, flush, wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  logic        ready_a, ins_valid_a, addr_err_a;
  logic [31:0] ins_out_a;
  logic        ready_b, ins_valid_b, addr_err_b;
  logic [31:0] ins_out_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_mem_fetch #(.ADDR_W(10), .DATA_W(32), .DEPTH(16), .NOP_WORD(NOP)) dut_a (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready_a), .ins_out(ins_out_a), .ins_valid(ins_valid_a), .addr_err(addr_err_a));

  instr_mem_fetch #(.ADDR_W(10), .DATA_W(32), .DEPTH(1000), .NOP_WORD(NOP)) dut_b (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready_b), .ins_out(ins_out_b), .ins_valid(ins_valid_b), .addr_err(addr_err_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_en = 1'b0; stall = 1'b0; flush = 1'b0; wr_en = 1'b0;
    pc = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    n_total++; if (ready_a !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready_a); else n_pass++;
    n_total++; if (ins_valid_a !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ins_valid_a); else n_pass++;
    n_total++; if (ins_out_a !== NOP) $display("FAIL reset_ins_out: got %h expected %h", ins_out_a, NOP); else n_pass++;
    n_total++; if (addr_err_a !== 1'b0) $display("FAIL reset_addr_err: got %b expected 0", addr_err_a); else n_pass++;
    rst_n = 1'b1;
  endtask

  // Inputs that INIT must ignore: a fetch request and a stray program write.
  task automatic test_init();
    fetch_en = 1'b1; pc = 10'd3;
    wr_en = 1'b1; wr_addr = 10'd3; wr_data = 32'hDEAD_BEEF;
    for (int e = 1; e <= 16; e++) begin
      tick();
      n_total++;
      if (ready_a !== (e == 16)) $display("FAIL init_ready_edge%0d: got %b expected %b", e, ready_a, e == 16);
      else n_pass++;
      n_total++;
      if (ins_valid_a !== 1'b0 || ins_valid_b !== 1'b0)
        $display("FAIL init_valid_edge%0d: got a=%b b=%b expected 0", e, ins_valid_a, ins_valid_b);
      else n_pass++;
    end
    n_total++; if (ins_out_a !== NOP) $display("FAIL init_ins_out: got %h expected %h", ins_out_a, NOP); else n_pass++;
    wr_en = 1'b0;
  endtask

  task automatic test_clear_sweep();
    fetch_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc = 10'(i);
      tick();
      n_total++;
      if (ins_out_a !== NOP || ins_valid_a !== 1'b1 || addr_err_a !== 1'b0)
        $display("FAIL sweep_pc%0d: got %h/%b/%b expected %h/1/0", i, ins_out_a, ins_valid_a, addr_err_a, NOP);
      else n_pass++;
    end
    fetch_en = 1'b0;
  endtask

  task automatic wait_ready_b(input int exp_edges, input string tag);
    int n;
    n = 0;
    while (ready_b !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    n_total++;
    if (ready_b !== 1'b1 || n != exp_edges)
      $display("FAIL %s: ready_b=%b after %0d edges expected 1 after %0d", tag, ready_b, n, exp_edges);
    else n_pass++;
  endtask

  task automatic test_load_fetch();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 10'd0; wr_data = W0; tick();
    wr_addr = 10'd7; wr_data = W7; tick();
    wr_en = 1'b0; fetch_en = 1'b1; pc = 10'd0; tick();
    n_total++;
    if (ins_out_a !== W0 || ins_out_b !== W0 || ins_valid_a !== 1'b1 || addr_err_b !== 1'b0)
      $display("FAIL load_pc0: got a=%h b=%h v=%b e=%b expected %h v=1 e=0", ins_out_a, ins_out_b, ins_valid_a, addr_err_b, W0);
    else n_pass++;
    pc = 10'd7; tick();
    n_total++;
    if (ins_out_a !== W7 || ins_out_b !== W7 || addr_err_a !== 1'b0)
      $display("FAIL load_pc7: got a=%h b=%h e=%b expected %h e=0", ins_out_a, ins_out_b, addr_err_a, W7);
    else n_pass++;
    fetch_en = 1'b0; tick();
    n_total++;
    if (ins_valid_a !== 1'b0 || ins_out_a !== W7)
      $display("FAIL load_idle: got v=%b out=%h expected v=0 out=%h", ins_valid_a, ins_out_a, W7);
    else n_pass++;
  endtask

  task automatic test_stall_flush();
    idle_inputs();
    fetch_en = 1'b1; pc = 10'd0; tick();
    n_total++; if (ins_out_b !== W0) $display("FAIL stall_pre: got %h expected %h", ins_out_b, W0); else n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 10'(7 + i);
      tick();
      n_total++;
      if (ins_out_a !== W0 || ins_out_b !== W0 || ins_valid_b !== 1'b1)
        $display("FAIL stall_hold%0d: got a=%h b=%h v=%b expected %h v=1", i, ins_out_a, ins_out_b, ins_valid_b, W0);
      else n_pass++;
    end
    flush = 1'b1; tick();
    n_total++;
    if (ins_out_a !== NOP || ins_out_b !== NOP || ins_valid_a !== 1'b1 || addr_err_a !== 1'b0)
      $display("FAIL flush_over_stall: got a=%h b=%h v=%b e=%b expected %h v=1 e=0", ins_out_a, ins_out_b, ins_valid_a, addr_err_a, NOP);
    else n_pass++;
    idle_inputs();
  endtask

  // DEPTH=1000 exercises pc==DEPTH, while DEPTH=16 catches address truncation on dropped writes.
  task automatic test_out_of_range();
    idle_inputs();
    fetch_en = 1'b1; pc = 10'd1000; tick();
    n_total++;
    if (ins_out_b !== NOP || addr_err_b !== 1'b1 || ins_valid_b !== 1'b1 || addr_err_a !== 1'b1)
      $display("FAIL oor_fetch1000: got b=%h e=%b v=%b a_e=%b expected %h e=1 v=1 a_e=1", ins_out_b, addr_err_b, ins_valid_b, addr_err_a, NOP);
    else n_pass++;
    fetch_en = 1'b0; wr_en = 1'b1; wr_addr = 10'd1023; wr_data = 32'h1234_5678; tick();
    n_total++;
    if (addr_err_b !== 1'b1 || ins_valid_b !== 1'b0)
      $display("FAIL oor_idle_hold: got e=%b v=%b expected e=1 v=0", addr_err_b, ins_valid_b);
    else n_pass++;
    wr_addr = 10'd1000; tick();
    wr_en = 1'b0; fetch_en = 1'b1; pc = 10'd999; tick();
    n_total++;
    if (ins_out_b !== NOP || addr_err_b !== 1'b0 || addr_err_a !== 1'b1)
      $display("FAIL oor_fetch999: got b=%h e=%b a_e=%b expected %h e=0 a_e=1", ins_out_b, addr_err_b, addr_err_a, NOP);
    else n_pass++;
    pc = 10'd15; tick();
    n_total++;
    if (ins_out_a !== NOP || addr_err_a !== 1'b0)
      $display("FAIL oor_drop_1023: got a=%h e=%b expected %h e=0", ins_out_a, addr_err_a, NOP);
    else n_pass++;
    pc = 10'd8; tick();
    n_total++;
    if (ins_out_a !== NOP) $display("FAIL oor_drop_1000: got %h expected %h", ins_out_a, NOP); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_read_during_write();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'hAAAA_0000; tick();
    wr_data = 32'hBBBB_0000; fetch_en = 1'b1; pc = 10'd5; tick();
    n_total++;
    if (ins_out_a !== 32'hAAAA_0000 || ins_out_b !== 32'hAAAA_0000)
      $display("FAIL rdw_old: got a=%h b=%h expected aaaa0000", ins_out_a, ins_out_b);
    else n_pass++;
    wr_en = 1'b0; tick();
    n_total++;
    if (ins_out_a !== 32'hBBBB_0000 || ins_out_b !== 32'hBBBB_0000)
      $display("FAIL rdw_new: got a=%h b=%h expected bbbb0000", ins_out_a, ins_out_b);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    fetch_en = 1'b1; pc = 10'd0; tick();
    n_total++; if (ins_out_a !== W0 || ins_valid_a !== 1'b1) $display("FAIL mrst_pre: got %h v=%b expected %h v=1", ins_out_a, ins_valid_a, W0); else n_pass++;
    fetch_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (ins_valid_a !== 1'b0 || ready_a !== 1'b0 || ready_b !== 1'b0 || ins_out_a !== NOP)
      $display("FAIL mrst_async: got v=%b ra=%b rb=%b out=%h expected 0/0/0/%h", ins_valid_a, ready_a, ready_b, ins_out_a, NOP);
    else n_pass++;
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e >= 15) begin
        n_total++;
        if (ready_a !== (e == 16)) $display("FAIL mrst_ready_edge%0d: got %b expected %b", e, ready_a, e == 16);
        else n_pass++;
      end
    end
    fetch_en = 1'b1; pc = 10'd0; tick();
    n_total++;
    if (ins_out_a !== NOP || ins_valid_a !== 1'b1)
      $display("FAIL mrst_a_cleared: got %h v=%b expected %h v=1", ins_out_a, ins_valid_a, NOP);
    else n_pass++;
    fetch_en = 1'b0;
    wait_ready_b(983, "mrst_b_ready");
    fetch_en = 1'b1; pc = 10'd0; tick();
    n_total++;
    if (ins_out_b !== NOP) $display("FAIL mrst_b_cleared: got %h expected %h", ins_out_b, NOP); else n_pass++;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_init();
    test_clear_sweep();
    wait_ready_b(968, "b_ready_edges");
    test_load_fetch();
    test_stall_flush();
    test_out_of_range();
    test_read_during_write();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
